// File: rtl/ti_packet_receiver_if.sv
// Router-side flit port plus header and payload streams of the task-injector receiver.
interface ti_packet_receiver_if #(
    parameter int FLIT_SIZE = 32
);
    logic                 rx_i;
    logic [FLIT_SIZE-1:0] data_i;
    logic                 credit_o;
    logic                 hdr_valid_o;
    logic                 hdr_ready_i;
    logic [31:0]          service_o;
    logic [31:0]          producer_o;
    logic [31:0]          consumer_o;
    logic [31:0]          source_o;
    logic [31:0]          msg_len_o;
    logic                 pl_valid_o;
    logic                 pl_ready_i;
    logic [FLIT_SIZE-1:0] pl_data_o;
    logic                 pl_last_o;
    logic                 err_o;

    modport master (
        output rx_i, data_i, hdr_ready_i, pl_ready_i,
        input  credit_o, hdr_valid_o, service_o, producer_o, consumer_o, source_o,
               msg_len_o, pl_valid_o, pl_data_o, pl_last_o, err_o
    );

    modport slave (
        input  rx_i, data_i, hdr_ready_i, pl_ready_i,
        output credit_o, hdr_valid_o, service_o, producer_o, consumer_o, source_o,
               msg_len_o, pl_valid_o, pl_data_o, pl_last_o, err_o
    );
endinterface

// File: rtl/ti_packet_receiver.sv
// NoC receiver: checks framing, decodes the service header, streams or drops the payload.
// Optional TI_RX_STATS_EN adds saturating packet / drop counters.
module ti_packet_receiver #(
    parameter int HEADER_SIZE = 13,
    parameter int FLIT_SIZE   = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
    ti_packet_receiver_if.slave bus
`ifdef TI_RX_STATS_EN
    ,
    output logic [31:0] rx_pkts_o,
    output logic [31:0] rx_drops_o
`endif
);
    localparam int IDX_W = $clog2(HEADER_SIZE);

    typedef enum logic [2:0] {
        S_IDLE, S_SIZE, S_HEADER, S_HDR_OUT, S_PAYLOAD, S_DROP
    } state_t;

    state_t state, state_nxt;

    logic [31:0]          cnt, cnt_dec, flit;
    logic [IDX_W-1:0]     idx;
    logic [31:0]          service_q, producer_q, consumer_q, source_q, msg_len_q;
    logic [FLIT_SIZE-1:0] pl_data_q;
    logic                 pl_valid_q, pl_last_q, err_q;
    logic                 credit_st, credit, xfer, err_set, hdr_last, svc_known, handoff;

    assign flit     = 32'(bus.data_i);
    assign cnt_dec  = (cnt != 32'd0) ? cnt - 32'd1 : cnt;
    assign hdr_last = (idx == IDX_W'(HEADER_SIZE - 1));
    assign handoff  = pl_valid_q && bus.pl_ready_i;

    // Service word is captured at index 0, long before the last header index.
    always_comb begin
        case (service_q)
            32'h0, 32'h1, 32'h26, 32'h31, 32'h34: svc_known = 1'b1;
            default:                              svc_known = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        credit_st = 1'b0;
        case (state)
            S_IDLE, S_SIZE, S_HEADER, S_DROP: credit_st = 1'b1;
            // Counter at 0 means the last flit is already held: refuse the next packet.
            S_PAYLOAD: credit_st = (cnt != 32'd0) && (!pl_valid_q || bus.pl_ready_i);
            default:   credit_st = 1'b0;
        endcase
        credit  = credit_st && rst_ni;
        xfer    = bus.rx_i && credit;
        err_set = 1'b0;
        case (state)
            S_IDLE: if (xfer) state_nxt = S_SIZE;
            S_SIZE: if (xfer) begin
                if (flit < 32'(HEADER_SIZE)) err_set = 1'b1;
                if (flit == 32'd0)                 state_nxt = S_IDLE;
                else if (flit < 32'(HEADER_SIZE))  state_nxt = S_DROP;
                else                               state_nxt = S_HEADER;
            end
            S_HEADER: if (xfer && hdr_last) begin
                if (svc_known) state_nxt = S_HDR_OUT;
                else begin
                    err_set   = 1'b1;
                    state_nxt = (cnt_dec != 32'd0) ? S_DROP : S_IDLE;
                end
            end
            S_HDR_OUT: if (bus.hdr_ready_i) state_nxt = (cnt != 32'd0) ? S_PAYLOAD : S_IDLE;
            S_PAYLOAD: if (handoff && pl_last_q) state_nxt = S_IDLE;
            S_DROP:    if (xfer && cnt_dec == 32'd0) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt        <= '0;
            idx        <= '0;
            service_q  <= '0;
            producer_q <= '0;
            consumer_q <= '0;
            source_q   <= '0;
            msg_len_q  <= '0;
            pl_data_q  <= '0;
            pl_valid_q <= 1'b0;
            pl_last_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= err_set;
            case (state)
                S_SIZE: if (xfer) begin
                    cnt <= flit;
                    idx <= '0;
                end
                S_HEADER: if (xfer) begin
                    cnt <= cnt_dec;
                    idx <= idx + IDX_W'(1);
                    if (idx == IDX_W'(0)) service_q  <= flit;
                    if (idx == IDX_W'(1)) producer_q <= flit;
                    if (idx == IDX_W'(2)) consumer_q <= flit;
                    if (idx == IDX_W'(3)) source_q   <= flit;
                    if (idx == IDX_W'(8)) msg_len_q  <= flit;
                end
                S_PAYLOAD: if (xfer) begin
                    pl_data_q  <= bus.data_i;
                    pl_valid_q <= 1'b1;
                    pl_last_q  <= (cnt == 32'd1);
                    cnt        <= cnt_dec;
                end else if (handoff) begin
                    pl_valid_q <= 1'b0;
                    pl_last_q  <= 1'b0;
                end
                S_DROP: if (xfer) cnt <= cnt_dec;
                default: ;
            endcase
        end
    end

`ifdef TI_RX_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_pkts_o  <= '0;
            rx_drops_o <= '0;
        end else begin
            if (state_nxt == S_HDR_OUT && state != S_HDR_OUT && rx_pkts_o != 32'hFFFF_FFFF)
                rx_pkts_o <= rx_pkts_o + 32'd1;
            if (err_set && rx_drops_o != 32'hFFFF_FFFF)
                rx_drops_o <= rx_drops_o + 32'd1;
        end
    end
`endif

    assign bus.credit_o    = credit;
    assign bus.hdr_valid_o = (state == S_HDR_OUT);
    assign bus.service_o   = service_q;
    assign bus.producer_o  = producer_q;
    assign bus.consumer_o  = consumer_q;
    assign bus.source_o    = source_q;
    assign bus.msg_len_o   = msg_len_q;
    assign bus.pl_valid_o  = pl_valid_q;
    assign bus.pl_data_o   = pl_data_q;
    assign bus.pl_last_o   = pl_last_q;
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_ti_packet_receiver.sv
// Directed bench for ti_packet_receiver: framing, header decode, payload skid, drop and reset.
module tb_ti_packet_receiver;
    localparam int HS = 13;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ti_packet_receiver_if #(.FLIT_SIZE(32)) bus ();
`ifdef TI_RX_STATS_EN
    logic [31:0] rx_pkts, rx_drops;
`endif

    ti_packet_receiver #(.HEADER_SIZE(HS), .FLIT_SIZE(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
`ifdef TI_RX_STATS_EN
        ,
        .rx_pkts_o  (rx_pkts),
        .rx_drops_o (rx_drops)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Monitor samples 1ns before each rising edge, when inputs and outputs are settled.
    int          err_pulses = 0, hv_cyc = 0, pv_cyc = 0, skid_bad = 0, stalls = 0;
    logic [31:0] got_q[$];
    logic        got_last[$];
    always begin
        @(negedge clk);
        #4;
        if (bus.err_o)       err_pulses++;
        if (bus.hdr_valid_o) hv_cyc++;
        if (bus.pl_valid_o)  pv_cyc++;
        if (bus.pl_valid_o && bus.pl_ready_i) begin
            got_q.push_back(bus.pl_data_o);
            got_last.push_back(bus.pl_last_o);
        end
        if (bus.pl_valid_o && !bus.pl_ready_i && bus.credit_o) skid_bad++;
        if (bus.rx_i && !bus.credit_o) stalls++;
    end

    function automatic logic [31:0] pl_at(input int i);
        return (i < got_q.size()) ? got_q[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic last_at(input int i);
        return (i < got_last.size()) ? got_last[i] : 1'bx;
    endfunction

    // Called at a falling edge; returns at the falling edge after the flit transferred.
    task automatic push(input logic [31:0] d);
        int n;
        n = 0;
        bus.rx_i   = 1'b1;
        bus.data_i = d;
        #1;
        while (!bus.credit_o && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("push_timeout", 32'(bus.credit_o), 32'd1);
        @(negedge clk);
        bus.rx_i = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] size, svc, w1, w2, w3, w8);
        logic [31:0] w;
        push(32'h0000_0102);
        push(size);
        for (int i = 0; i < HS; i++) begin
            case (i)
                0:       w = svc;
                1:       w = w1;
                2:       w = w2;
                3:       w = w3;
                8:       w = w8;
                default: w = 32'hD0D0_0000 + 32'(i);
            endcase
            push(w);
        end
    endtask

    task automatic take_hdr();
        bus.hdr_ready_i = 1'b1;
        @(negedge clk);
        bus.hdr_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base, e0, h0, p0, s0;
        logic [3:0]  pat;
        bus.rx_i = 1'b0; bus.data_i = '0; bus.hdr_ready_i = 1'b0; bus.pl_ready_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_credit",  32'(bus.credit_o),    32'd0);
        chk("rst_hvalid",  32'(bus.hdr_valid_o), 32'd0);
        chk("rst_pvalid",  32'(bus.pl_valid_o),  32'd0);
        chk("rst_plast",   32'(bus.pl_last_o),   32'd0);
        chk("rst_err",     32'(bus.err_o),       32'd0);
        chk("rst_service", bus.service_o,        32'd0);
        chk("rst_msglen",  bus.msg_len_o,        32'd0);
        rst_n = 1'b1;
        bus.pl_ready_i = 1'b1;

        // MESSAGE_DELIVERY with three payload flits
        send_hdr(32'd16, 32'h1, 32'h100, 32'h101, 32'h0203, 32'd3);
        chk("t1_hvalid",   32'(bus.hdr_valid_o), 32'd1);
        chk("t1_service",  bus.service_o,  32'h1);
        chk("t1_producer", bus.producer_o, 32'h100);
        chk("t1_consumer", bus.consumer_o, 32'h101);
        chk("t1_source",   bus.source_o,   32'h0203);
        chk("t1_msglen",   bus.msg_len_o,  32'd3);
        chk("t1_nocredit", 32'(bus.credit_o), 32'd0);
        take_hdr();
        chk("t1_hv_drop",  32'(bus.hdr_valid_o), 32'd0);
        base = got_q.size();
        push(32'hA);
        chk("t1_lat_vld",  32'(bus.pl_valid_o), 32'd1);
        chk("t1_lat_data", bus.pl_data_o, 32'hA);
        push(32'hB);
        push(32'hC);
        repeat (3) @(negedge clk);
        chk("t1_npl",   32'(got_q.size() - base), 32'd3);
        chk("t1_pl0",   pl_at(base),     32'hA);
        chk("t1_pl1",   pl_at(base + 1), 32'hB);
        chk("t1_pl2",   pl_at(base + 2), 32'hC);
        chk("t1_last0", 32'(last_at(base)),     32'd0);
        chk("t1_last1", 32'(last_at(base + 1)), 32'd0);
        chk("t1_last2", 32'(last_at(base + 2)), 32'd1);
        chk("t1_idle",  32'(bus.credit_o),   32'd1);
        chk("t1_pvlow", 32'(bus.pl_valid_o), 32'd0);

        // DATA_AV with no payload
        p0 = pv_cyc;
        send_hdr(32'd13, 32'h31, 32'h200, 32'h201, 32'h0304, 32'd0);
        chk("t2_hvalid",  32'(bus.hdr_valid_o), 32'd1);
        chk("t2_service", bus.service_o, 32'h31);
        chk("t2_source",  bus.source_o,  32'h0304);
        take_hdr();
        chk("t2_hv_drop", 32'(bus.hdr_valid_o), 32'd0);
        chk("t2_idle",    32'(bus.credit_o), 32'd1);
        repeat (2) @(negedge clk);
        chk("t2_no_pl",   32'(pv_cyc - p0), 32'd0);

        // Unknown service: one error pulse, payload swallowed without stalls
        e0 = err_pulses; h0 = hv_cyc; p0 = pv_cyc;
        send_hdr(32'd20, 32'h55, 32'h1, 32'h2, 32'h3, 32'd7);
        s0 = stalls;
        for (int i = 0; i < 7; i++) push(32'hE000_0000 + 32'(i));
        repeat (2) @(negedge clk);
        chk("t3_err",    32'(err_pulses - e0), 32'd1);
        chk("t3_stalls", 32'(stalls - s0),     32'd0);
        chk("t3_no_hv",  32'(hv_cyc - h0),     32'd0);
        chk("t3_no_pl",  32'(pv_cyc - p0),     32'd0);
        chk("t3_idle",   32'(bus.credit_o),    32'd1);

        // SIZE below header length, then a good MESSAGE_REQUEST
        e0 = err_pulses;
        push(32'h0000_0102);
        push(32'd5);
        chk("t4_errpulse", 32'(bus.err_o), 32'd1);
        for (int i = 0; i < 5; i++) push(32'hF000_0000 + 32'(i));
        send_hdr(32'd15, 32'h0, 32'h11, 32'h22, 32'h33, 32'd2);
        chk("t4_err",      32'(err_pulses - e0), 32'd1);
        chk("t4_hvalid",   32'(bus.hdr_valid_o), 32'd1);
        chk("t4_service",  bus.service_o,  32'h0);
        chk("t4_producer", bus.producer_o, 32'h11);
        chk("t4_consumer", bus.consumer_o, 32'h22);
        chk("t4_msglen",   bus.msg_len_o,  32'd2);
        take_hdr();
        base = got_q.size();
        push(32'h77);
        push(32'h78);
        repeat (3) @(negedge clk);
        chk("t4_npl",   32'(got_q.size() - base), 32'd2);
        chk("t4_pl0",   pl_at(base),     32'h77);
        chk("t4_pl1",   pl_at(base + 1), 32'h78);
        chk("t4_last1", 32'(last_at(base + 1)), 32'd1);

        // Back-pressure pattern 1,0,0,1 on the payload stream
        send_hdr(32'd17, 32'h1, 32'h5, 32'h6, 32'h7, 32'd4);
        take_hdr();
        base = got_q.size();
        pat  = 4'b1001;
        fork
            begin
                for (int i = 0; i < 4; i++) push(32'h10 + 32'(i));
            end
            begin
                for (int k = 0; k < 12; k++) begin
                    bus.pl_ready_i = pat[k % 4];
                    @(negedge clk);
                end
                bus.pl_ready_i = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        chk("t5_npl",   32'(got_q.size() - base), 32'd4);
        chk("t5_pl0",   pl_at(base),     32'h10);
        chk("t5_pl1",   pl_at(base + 1), 32'h11);
        chk("t5_pl2",   pl_at(base + 2), 32'h12);
        chk("t5_pl3",   pl_at(base + 3), 32'h13);
        chk("t5_last2", 32'(last_at(base + 2)), 32'd0);
        chk("t5_last3", 32'(last_at(base + 3)), 32'd1);
        chk("t5_skid",  32'(skid_bad), 32'd0);
        chk("t5_idle",  32'(bus.credit_o), 32'd1);

`ifdef TI_RX_STATS_EN
        chk("st_pkts_pre",  rx_pkts,  32'd4);
        chk("st_drops_pre", rx_drops, 32'd2);
`endif

        // Reset asserted while header index 6 is offered
        push(32'h0000_0102);
        push(32'd16);
        for (int i = 0; i < 6; i++) push((i == 0) ? 32'h1 : 32'hC000_0000 + 32'(i));
        bus.rx_i   = 1'b1;
        bus.data_i = 32'hC000_0006;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_credit",  32'(bus.credit_o),    32'd0);
        chk("t6_hvalid",  32'(bus.hdr_valid_o), 32'd0);
        chk("t6_service", bus.service_o,        32'd0);
        chk("t6_pvalid",  32'(bus.pl_valid_o),  32'd0);
        chk("t6_err",     32'(bus.err_o),       32'd0);
`ifdef TI_RX_STATS_EN
        chk("st_pkts_rst", rx_pkts, 32'd0);
`endif
        bus.rx_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_hdr(32'd13, 32'h34, 32'h400, 32'h401, 32'h402, 32'd0);
        chk("t6_hv_after",  32'(bus.hdr_valid_o), 32'd1);
        chk("t6_svc_after", bus.service_o, 32'h34);
        chk("t6_src_after", bus.source_o,  32'h402);
        take_hdr();
`ifdef TI_RX_STATS_EN
        chk("st_pkts_post",  rx_pkts,  32'd1);
        chk("st_drops_post", rx_drops, 32'd0);
`endif
        repeat (2) @(negedge clk);
        chk("end_skid", 32'(skid_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
